// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: L1 D-cache memory request port to AXI4 single-beat bridge.
// One transaction in flight. Writes complete on the B response.
// Ports:
//   clk, rstn      clock, async active-low reset
//   dcache_mem_*   cache request (req/wr/size/wstrb/addr/data)
//   mem_dcache_*   addrOK (comb), dataOK (1-cycle pulse), rdata
//   ar*/r*/aw*/w*/b*  AXI4 channels, single beat, no wlast
//   bus_err        sticky bus error flag
// Macro DCACHE_BRIDGE_ERRLATCH_EN enables bus_err latching on error responses;
// when undefined bus_err is tied low and rresp/bresp are ignored.
module dcache_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dcache_mem_req,
    input  logic              dcache_mem_wr,
    input  logic [1:0]        dcache_mem_size,
    input  logic [3:0]        dcache_mem_wstrb,
    input  logic [ADDR_W-1:0] dcache_mem_addr,
    input  logic [DATA_W-1:0] dcache_mem_data,
    output logic              mem_dcache_addrOK,
    output logic              mem_dcache_dataOK,
    output logic [DATA_W-1:0] mem_dcache_rdata,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              bus_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        size_q;
    logic              aw_done;
    logic              w_done;
    logic              dataok_q;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_ok;
    logic              aw_hs;
    logic              w_hs;

    // The dataOK cycle is already back in IDLE; hold off acceptance for
    // that one cycle so addrOK and dataOK never coincide.
    assign addr_ok = (state == IDLE) & dcache_mem_req & ~dataok_q;

    // Valids/readies decode straight from state so reset drops them at once.
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);
    assign awvalid = (state == WR_REQ) & ~aw_done;
    assign wvalid  = (state == WR_REQ) & ~w_done;
    assign bready  = (state == WR_RESP);

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = data_q;
    assign wstrb  = wstrb_q;

    assign mem_dcache_addrOK = addr_ok;
    assign mem_dcache_dataOK = dataok_q;
    assign mem_dcache_rdata  = rdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            wstrb_q  <= '0;
            size_q   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            dataok_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            dataok_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (addr_ok) begin
                        addr_q  <= dcache_mem_addr;
                        data_q  <= dcache_mem_data;
                        wstrb_q <= dcache_mem_wstrb;
                        size_q  <= dcache_mem_size;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= dcache_mem_wr ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rdata_q  <= rdata;
                        dataok_q <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs))
                        state <= WR_RESP;
                end
                WR_RESP: begin
                    if (bvalid) begin
                        dataok_q <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_BRIDGE_ERRLATCH_EN
    logic       err_ev;
    logic       bus_err_q;
    logic [3:0] err_cnt;

    assign err_ev = ((state == RD_DATA) & rvalid & (|rresp))
                  | ((state == WR_RESP) & bvalid & (|bresp));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_err_q <= 1'b0;
            err_cnt   <= '0;
        end else if (err_ev) begin
            bus_err_q <= 1'b1;
            if (err_cnt != 4'hf) err_cnt <= err_cnt + 4'd1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb_dcache_axi_bridge: randomized transactions against a transaction-level
// model of the cache port and an AXI slave with random delays.
module tb_dcache_axi_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  mwstrb;
    logic [31:0] maddr, mdata;
    logic        addrok, dataok;
    logic [31:0] mrdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid, bready, bus_err;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    dcache_axi_bridge dut (
        .clk(clk), .rstn(rstn),
        .dcache_mem_req(req), .dcache_mem_wr(wr),
        .dcache_mem_size(size), .dcache_mem_wstrb(mwstrb),
        .dcache_mem_addr(maddr), .dcache_mem_data(mdata),
        .mem_dcache_addrOK(addrok), .mem_dcache_dataOK(dataok),
        .mem_dcache_rdata(mrdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_err(bus_err)
    );

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [1:0]  size;
        bit [3:0]  wstrb;
        bit [31:0] data;
        bit [31:0] rd;
        int        ard, rdd, awd, wd, bd;
        bit [1:0]  resp;
        bit        rst;
        int        gap;
    } txn_t;

    txn_t tq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(bit w, bit [31:0] a, bit [1:0] s,
                                bit [3:0] st, bit [31:0] d, bit [31:0] r,
                                int ard, int rdd, int awd, int wd, int bd,
                                bit [1:0] resp, bit rst, int gap);
        txn_t t;
        t.wr = w; t.addr = a; t.size = s; t.wstrb = st;
        t.data = d; t.rd = r;
        t.ard = ard; t.rdd = rdd; t.awd = awd; t.wd = wd; t.bd = bd;
        t.resp = resp; t.rst = rst; t.gap = gap;
        return t;
    endfunction

    // model state
    bit        active;
    txn_t      cur;
    int        cur_idx, nxt, gap, cyc, acc_cyc;
    int        n_done, n_abort;
    bit        ar_d, r_d, aw_d, w_d, b_d;
    int        ar_c, r_c, aw_c, w_c, b_c;
    bit [31:0] last_rd;
    bit        err_seen;
    bit        exp_aok;

    function automatic bit exp_err();
`ifdef DCACHE_BRIDGE_ERRLATCH_EN
        return err_seen;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_arvalid"}, arvalid, 0);
        chk({pfx, "_rready"},  rready,  0);
        chk({pfx, "_awvalid"}, awvalid, 0);
        chk({pfx, "_wvalid"},  wvalid,  0);
        chk({pfx, "_bready"},  bready,  0);
        chk({pfx, "_dataok"},  dataok,  0);
        chk({pfx, "_rdata"},   mrdata,  0);
        chk({pfx, "_bus_err"}, bus_err, 0);
    endtask

    task automatic slave_quiet();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rresp = 0; bresp = 0; rdata = 0;
    endtask

    initial begin
        rstn = 0; req = 0; wr = 0; size = 0; mwstrb = 0;
        maddr = 0; mdata = 0;
        slave_quiet();
        active = 0; nxt = 0; cyc = 0; n_done = 0; n_abort = 0;
        last_rd = 0; err_seen = 0;

        // directed head, then random tail
        tq.push_back(mk(0, 32'h0000_1004, 2, 4'h0, 0, 32'hDEADBEEF,
                        0, 0, 0, 0, 0, 0, 0, 0));
        tq.push_back(mk(1, 32'h0000_0020, 2, 4'hF, 32'h12345678, 0,
                        0, 0, 0, 2, 0, 2'b10, 0, 0));
        tq.push_back(mk(0, 32'h0000_0040, 2, 4'h0, 0, 32'hCAFE0001,
                        0, 0, 0, 0, 0, 0, 0, 0));
        tq.push_back(mk(0, 32'h0000_0100, 1, 4'h0, 0, 32'h0BAD_F00D,
                        5, 1, 0, 0, 0, 0, 0, 0));
        tq.push_back(mk(1, 32'h0000_0203, 3, 4'h8, 32'hA5A5_5A5A, 0,
                        1, 0, 0, 0, 1, 0, 0, 0));
        tq.push_back(mk(0, 32'h0000_0300, 2, 4'h0, 0, 32'h1111_2222,
                        0, 4, 0, 0, 0, 0, 1, 0));
        tq.push_back(mk(0, 32'h0000_0304, 0, 4'h0, 0, 32'h3333_4444,
                        0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 40; i++) begin
            tq.push_back(mk($urandom % 2, $urandom, 2'($urandom % 4),
                4'($urandom), $urandom, $urandom,
                $urandom % 4, $urandom % 4, $urandom % 4,
                $urandom % 4, $urandom % 4,
                ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                0, $urandom % 3));
        end
        gap = tq[0].gap;

        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_addrok", addrok, 0);
        rstn = 1;

        while ((nxt < tq.size() || active) && cyc < 4000) begin
            @(negedge clk);

            if (active && cur.rst && rready) begin
                slave_quiet();
                req = 0;
                rstn = 0;
                #1;
                chk_idle_outputs("midrst");
                active = 0; n_abort++; last_rd = 0; err_seen = 0;
                @(negedge clk);
                rstn = 1;
                cyc++;
                continue;
            end

            if (nxt < tq.size()) begin
                if (gap > 0) begin
                    req = 0;
                    gap--;
                end else begin
                    req = 1;
                    wr = tq[nxt].wr;
                    maddr = tq[nxt].addr;
                    size = tq[nxt].size;
                    mwstrb = tq[nxt].wstrb;
                    mdata = tq[nxt].data;
                end
            end else begin
                req = 0;
            end

            arready = arvalid && (ar_c >= cur.ard);
            rvalid  = rready  && (r_c  >= cur.rdd);
            rdata   = rvalid ? cur.rd : $urandom;
            rresp   = cur.resp;
            awready = awvalid && (aw_c >= cur.awd);
            wready  = wvalid  && (w_c  >= cur.wd);
            bvalid  = bready  && (b_c  >= cur.bd);
            bresp   = cur.resp;
            #1;

            chk("arvalid", arvalid, active && !cur.wr && !ar_d);
            chk("rready", rready, active && !cur.wr && ar_d && !r_d);
            chk("awvalid", awvalid, active && cur.wr && !aw_d);
            chk("wvalid", wvalid, active && cur.wr && !w_d);
            chk("bready", bready,
                active && cur.wr && aw_d && w_d && !b_d);
            if (arvalid) begin
                chk("araddr", araddr, cur.addr);
                chk("arsize", arsize, {1'b0, cur.size});
            end
            if (awvalid) begin
                chk("awaddr", awaddr, cur.addr);
                chk("awsize", awsize, {1'b0, cur.size});
            end
            if (wvalid) begin
                chk("wdata", wdata, cur.data);
                chk("wstrb", wstrb, cur.wstrb);
            end
            chk("dataok", dataok, active && (cur.wr ? b_d : r_d));
            if (dataok) chk("rdata", mrdata, last_rd);
            exp_aok = req && !active;
            chk("addrok", addrok, exp_aok);
            chk("bus_err", bus_err, exp_err());

            if (active) begin
                if (arvalid && arready) ar_d = 1;
                else if (arvalid) ar_c++;
                if (rvalid && rready) begin
                    r_d = 1; last_rd = cur.rd;
                    if (cur.resp != 0) err_seen = 1;
                end else if (rready) r_c++;
                if (awvalid && awready) aw_d = 1;
                else if (awvalid) aw_c++;
                if (wvalid && wready) w_d = 1;
                else if (wvalid) w_c++;
                if (bvalid && bready) begin
                    b_d = 1;
                    if (cur.resp != 0) err_seen = 1;
                end else if (bready) b_c++;
            end

            if (active && dataok) begin
                active = 0;
                n_done++;
                if (cur_idx == 0) chk("rd_latency", cyc - acc_cyc, 3);
                if (cur_idx == 1) chk("wr_latency", cyc - acc_cyc, 5);
            end else if (active && (cyc - acc_cyc > 60)) begin
                chk("txn_timeout", dataok, 1);
                active = 0;
            end

            if (exp_aok && addrok) begin
                cur = tq[nxt];
                cur_idx = nxt;
                nxt++;
                active = 1;
                acc_cyc = cyc;
                ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
                ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
                gap = (nxt < tq.size()) ? tq[nxt].gap : 0;
            end
            cyc++;
        end

        chk("completed", n_done, tq.size() - n_abort);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
